inverse_comb_filter: RTL and testbench

- Feed-forward (FIR) comb filter: out[n] = in[n] - g * in[n - tau].
- Exact inverse of the feedback comb filter with the same tau/gain, so it undoes a comb stage's colouring.
- Used as the decode-side stage in reverb calibration paths and in loopback self-test behind a feedback comb.
- Runs on the system clock, advanced by a one-cycle sample strobe, with an internal circular delay buffer in inferred BRAM.

---
 rtl/inverse_comb_filter_if.sv | 30 +++
 rtl/inverse_comb_filter.sv | 150 +++++++++++++++
 tb/tb_inverse_comb_filter.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/inverse_comb_filter_if.sv
// Sample-stream bus for the inverse comb filter: strobe, sample, delay and
// gain in; filtered sample, valid pulse and sticky overrun flag out.
`ifndef FIXED_POINT
`define FIXED_POINT 8
`endif
`ifndef MAX_FILTER_FIFO_LENGTH
`define MAX_FILTER_FIFO_LENGTH 1024
`endif

interface inverse_comb_filter_if #(
  parameter int WORD = 32
);
  logic                   sample_en;
  logic signed [WORD-1:0] in;
  logic signed [WORD-1:0] tau;
  logic signed [WORD-1:0] gain;
  logic signed [WORD-1:0] out;
  logic                   out_valid;
  logic                   overrun;

  modport master (
    output sample_en, in, tau, gain,
    input  out, out_valid, overrun
  );

  modport slave (
    input  sample_en, in, tau, gain,
    output out, out_valid, overrun
  );
endinterface

// File: rtl/inverse_comb_filter.sv
// Feed-forward comb filter out[n] = in[n] - g*in[n-d], the exact inverse of a
// feedback comb; one sample in flight through a four-state pipeline.
`ifndef FIXED_POINT
`define FIXED_POINT 8
`endif
`ifndef MAX_FILTER_FIFO_LENGTH
`define MAX_FILTER_FIFO_LENGTH 1024
`endif

module inverse_comb_filter #(
  parameter int WIDTH  = 24,
  parameter int FRAC   = `FIXED_POINT,
  parameter int MAXLEN = `MAX_FILTER_FIFO_LENGTH
) (
  input  logic                clk,
  input  logic                rstn,
  inverse_comb_filter_if.slave bus
);
  localparam int WORD = WIDTH + FRAC;
  localparam int AW   = $clog2(MAXLEN);
  localparam int PW   = 2 * WORD;

  localparam logic signed [WORD-1:0] D_MIN     = WORD'(1);
  localparam logic signed [WORD-1:0] D_MAX     = WORD'(MAXLEN - 1);
  localparam logic [AW:0]            FILL_FULL = (AW+1)'(MAXLEN);
  localparam logic [AW:0]            FILL_ONE  = (AW+1)'(1);
  localparam logic signed [PW:0]     SAT_HI    = $signed({{(PW-WORD+2){1'b0}}, {(WORD-1){1'b1}}});
  localparam logic signed [PW:0]     SAT_LO    = $signed({{(PW-WORD+2){1'b1}}, {(WORD-1){1'b0}}});

  typedef enum logic [1:0] {S_IDLE, S_READ, S_MULT, S_OUT} state_t;
  state_t state, state_next;

  logic                   accept, busy_strobe, load_delay, load_prod, load_out;
  logic signed [WORD-1:0] tau_int;
  logic [AW-1:0]          d_new, wp, raddr;
  logic [AW:0]            fill, fill_next;
  logic                   hit;
  logic signed [WORD-1:0] in_reg, g_reg, delayed, rdata, diff_sat;
  logic signed [PW-1:0]   g_ext, dly_ext, mult, prod;
  logic signed [PW:0]     diff;
  logic [WORD-1:0]        mem [MAXLEN];

  always_comb begin
    state_next  = state;
    accept      = 1'b0;
    busy_strobe = 1'b0;
    load_delay  = 1'b0;
    load_prod   = 1'b0;
    load_out    = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.sample_en) begin
          accept     = 1'b1;
          state_next = S_READ;
        end
      end
      S_READ: begin
        busy_strobe = bus.sample_en;
        load_delay  = 1'b1;
        state_next  = S_MULT;
      end
      S_MULT: begin
        busy_strobe = bus.sample_en;
        load_prod   = 1'b1;
        state_next  = S_OUT;
      end
      S_OUT: begin
        busy_strobe = bus.sample_en;
        load_out    = 1'b1;
        state_next  = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Clamping d to at least 1 keeps the read address off the write address.
  always_comb begin
    tau_int = bus.tau >>> FRAC;
    if (tau_int < D_MIN) begin
      d_new = D_MIN[AW-1:0];
    end else if (tau_int > D_MAX) begin
      d_new = D_MAX[AW-1:0];
    end else begin
      d_new = tau_int[AW-1:0];
    end
    raddr     = wp - d_new;
    fill_next = (fill == FILL_FULL) ? fill : fill + FILL_ONE;
  end

  always_comb begin
    g_ext   = $signed({{WORD{g_reg[WORD-1]}}, g_reg});
    dly_ext = $signed({{WORD{delayed[WORD-1]}}, delayed});
    mult    = g_ext * dly_ext;
    diff    = $signed({{(PW-WORD+1){in_reg[WORD-1]}}, in_reg}) - $signed({prod[PW-1], prod});
    if (diff > SAT_HI) begin
      diff_sat = $signed({1'b0, {(WORD-1){1'b1}}});
    end else if (diff < SAT_LO) begin
      diff_sat = $signed({1'b1, {(WORD-1){1'b0}}});
    end else begin
      diff_sat = diff[WORD-1:0];
    end
  end

  // Delay line kept reset-free so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wp] <= bus.in;
    end
    rdata <= mem[raddr];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= S_IDLE;
      wp            <= '0;
      fill          <= '0;
      hit           <= 1'b0;
      in_reg        <= '0;
      g_reg         <= '0;
      delayed       <= '0;
      prod          <= '0;
      bus.out       <= '0;
      bus.out_valid <= 1'b0;
      bus.overrun   <= 1'b0;
    end else begin
      state         <= state_next;
      bus.out_valid <= 1'b0;
      if (accept) begin
        in_reg <= bus.in;
        g_reg  <= bus.gain;
        hit    <= fill_next > {1'b0, d_new};
        wp     <= wp + AW'(1);
        fill   <= fill_next;
      end
      if (busy_strobe) begin
        bus.overrun <= 1'b1;
      end
      if (load_delay) begin
        delayed <= hit ? rdata : '0;
      end
      if (load_prod) begin
        prod <= mult >>> FRAC;
      end
      if (load_out) begin
        bus.out       <= diff_sat;
        bus.out_valid <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_inverse_comb_filter.sv
// Scoreboard bench for inverse_comb_filter: a plain-arithmetic model of
// out[n] = sat(in[n] - (g*in[n-d])>>>FRAC) feeds a queue the monitor drains.
module tb_inverse_comb_filter;
  localparam int WIDTH  = 24;
  localparam int FRAC   = 8;
  localparam int MAXLEN = 1024;
  localparam int WORD   = WIDTH + FRAC;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   cycle = 0;
  int   tests_run = 0;
  int   tests_failed = 0;

  typedef struct {
    longint value;
    int     due;
  } exp_t;

  exp_t   exp_q[$];
  longint hist[$];

  inverse_comb_filter_if #(.WORD(WORD)) bus ();

  inverse_comb_filter #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC),
    .MAXLEN(MAXLEN)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check_output(input string name, input logic signed [63:0] actual,
                              input logic signed [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Reference: history of accepted inputs since reset, missing history is zero.
  function automatic longint model_step(input longint x, input int tau_v, input int gain_v);
    int     d;
    int     n;
    longint delayed;
    longint prod;
    longint diff;
    d = tau_v >>> FRAC;
    if (d < 1) d = 1;
    if (d > MAXLEN - 1) d = MAXLEN - 1;
    hist.push_back(x);
    n = hist.size() - 1;
    delayed = (n >= d) ? hist[n - d] : 0;
    prod = (longint'(gain_v) * delayed) >>> FRAC;
    diff = x - prod;
    if (diff > 64'sd2147483647) diff = 64'sd2147483647;
    if (diff < -64'sd2147483648) diff = -64'sd2147483648;
    return diff;
  endfunction

  task automatic apply_stimulus(input logic signed [31:0] x, input logic signed [31:0] t,
                                input logic signed [31:0] g);
    exp_t e;
    bus.sample_en = 1'b1;
    bus.in        = x;
    bus.tau       = t;
    bus.gain      = g;
    e.value = model_step(longint'(x), int'(t), int'(g));
    e.due   = cycle + 4;
    exp_q.push_back(e);
    @(negedge clk);
    bus.sample_en = 1'b0;
    bus.in        = $urandom;
    bus.tau       = $urandom;
    bus.gain      = $urandom;
    repeat (3) @(negedge clk);
  endtask

  task automatic impulse(input logic signed [31:0] t, input logic signed [31:0] g,
                         input int zeros);
    apply_stimulus(32'sd256, t, g);
    for (int i = 0; i < zeros; i++) apply_stimulus(32'sd0, t, g);
  endtask

  task automatic drain_and_check(input string name);
    repeat (3) @(negedge clk);
    check_output(name, exp_q.size(), 0);
  endtask

  task automatic check_reset_state(input string tag);
    check_output({tag, "_out"}, bus.out, 0);
    check_output({tag, "_out_valid"}, bus.out_valid, 0);
    check_output({tag, "_overrun"}, bus.overrun, 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rstn && bus.out_valid) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL unexpected_valid: out=%0d at cycle %0d, expected no output", bus.out, cycle);
      end else begin
        e = exp_q.pop_front();
        check_output("out", bus.out, e.value);
        check_output("latency", cycle, e.due);
      end
    end
  end

  initial begin
    logic signed [31:0] x, t, g;
    exp_t e;
    bus.sample_en = 1'b0;
    bus.in        = '0;
    bus.tau       = '0;
    bus.gain      = '0;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rstn = 1'b1;
    @(negedge clk);

    impulse(32'sd4 <<< 8, 32'sd128, 7);

    foreach (x[i]) x[i] = 1'b0;
    for (int i = 0; i < 13; i++) begin
      x = ((i % 4) == 0) ? (32'sd256 >>> (i / 4)) : 32'sd0;
      apply_stimulus(x, 32'sd4 <<< 8, 32'sd128);
    end

    apply_stimulus(32'sh7fffffff, 32'sd1 <<< 8, 32'sd256);
    apply_stimulus(32'sh80000000, 32'sd1 <<< 8, 32'sd256);
    apply_stimulus(32'sh80000000, 32'sd1 <<< 8, 32'sd256);
    apply_stimulus(32'sh7fffffff, 32'sd1 <<< 8, 32'sd256);

    impulse(32'sd0, 32'sd128, 3);
    impulse(32'sd5000 <<< 8, 32'sd128, 1030);

    for (int i = 0; i < 300; i++) begin
      x = ($urandom_range(0, 3) == 0) ? $signed($urandom) : $signed(32'($urandom_range(0, 200000)) - 32'sd100000);
      t = $signed((32'($urandom_range(0, 1100)) << 8) | 32'($urandom_range(0, 255)));
      if ($urandom_range(0, 9) == 0) t = -t;
      g = $signed(32'($urandom_range(0, 2048)) - 32'sd1024);
      apply_stimulus(x, t, g);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain_and_check("random_drain");
    check_output("overrun_clear", bus.overrun, 0);

    // Back-to-back strobes: only the first is taken.
    bus.sample_en = 1'b1;
    bus.in        = 32'sd256;
    bus.tau       = 32'sd4 <<< 8;
    bus.gain      = 32'sd128;
    e.value = model_step(64'sd256, 4 <<< 8, 128);
    e.due   = cycle + 4;
    exp_q.push_back(e);
    @(negedge clk);
    bus.in = 32'sd9999;
    @(negedge clk);
    bus.sample_en = 1'b0;
    repeat (2) @(negedge clk);
    check_output("overrun_set", bus.overrun, 1);
    for (int i = 0; i < 6; i++) apply_stimulus(32'sd0, 32'sd4 <<< 8, 32'sd128);
    check_output("overrun_sticky", bus.overrun, 1);

    for (int i = 0; i < 2000; i++) begin
      x = $signed(32'($urandom_range(1, 100000)));
      if ($urandom_range(0, 1) == 1) x = -x;
      t = $signed(32'($urandom_range(1, 1500)) << 8);
      g = $signed(32'($urandom_range(0, 512)) - 32'sd256);
      apply_stimulus(x, t, g);
    end
    drain_and_check("warmup_drain");

    // Reset lands while a sample is in flight; it must never emerge.
    bus.sample_en = 1'b1;
    bus.in        = 32'sd777;
    bus.tau       = 32'sd3 <<< 8;
    bus.gain      = 32'sd256;
    @(negedge clk);
    bus.sample_en = 1'b0;
    rstn = 1'b0;
    hist.delete();
    #1;
    check_reset_state("abort_reset");
    @(negedge clk);
    rstn = 1'b1;
    repeat (5) @(negedge clk);
    check_output("abort_no_output", exp_q.size(), 0);

    for (int i = 0; i < 16; i++) apply_stimulus(32'sd100, 32'sd10 <<< 8, 32'sd256);
    drain_and_check("final_drain");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
